ws2812b_idle_monitor: RTL and testbench
=======================================

Name: ws2812b_idle_monitor

Overview:
Multi-channel WS2812B line-idle (latch/reset) monitor for the impostor_ws2812b peripheral. Each channel synchronises its data input and removes short glitches with a programmable deglitch filter. It then counts low time against a shared, runtime-programmable threshold. Outputs are a per-channel idle level, one-cycle idle_start/frame_start event pulses, and aggregate any/all flags for the register interface.

Parameters:
NUM_CH, 4, number of monitored data lines
CNT_W, 16, width of idle counter and threshold
GLITCH_W, 3, width of deglitch threshold
SYNC_STAGES, 2, synchroniser flops per channel (>=1)

Ports:
clk  input  1  system clock
reset  input  1  synchronous, active-high reset
din  input  NUM_CH  asynchronous WS2812B data lines
enable_mask  input  NUM_CH  per-channel enable for idle counting
idle_threshold  input  CNT_W  low-time threshold in clock cycles (sampled live)
glitch_ticks  input  GLITCH_W  deglitch length; a level change is accepted after glitch_ticks+1 stable cycles
idle  output  NUM_CH  registered idle level per channel
idle_start  output  NUM_CH  one-cycle pulse when idle rises
frame_start  output  NUM_CH  one-cycle pulse when idle falls (new frame data seen)
any_idle  output  1  OR of idle
all_idle  output  1  every enabled channel idle; 0 when enable_mask==0

Behaviour:
- Clock is clk. Reset is synchronous, active-high, on the port named reset. It clears all synchroniser flops, the filtered level f, deglitch counters, idle counters, idle, idle_start and frame_start to 0. any_idle and all_idle are therefore 0 during reset.
- Synchroniser: din[i] passes through SYNC_STAGES flops to give s[i]. It always runs, whatever enable_mask is.
- Deglitch, per channel, always running. Each edge:
  - if s==f: gcnt<=0
  - else if gcnt>=glitch_ticks: f<=s, gcnt<=0
  - else: gcnt<=gcnt+1
  - Consequence: s must differ from f on glitch_ticks+1 consecutive edges. glitch_ticks=0 gives a one-cycle filter delay.
- Idle counter, per channel, cnt is CNT_W bits:
  - enable_mask[i]==0: cnt<=0, idle<=0, no pulses.
  - f==1: cnt<=0, idle<=0. frame_start<=idle, so it pulses exactly when idle falls from 1.
  - f==0 and cnt<idle_threshold: cnt<=cnt+1. No overflow is possible.
  - f==0 and cnt>=idle_threshold and idle==0: idle<=1, idle_start<=1.
  - f==0 and idle==1: hold.
- idle_start and frame_start default to 0 every cycle; each is a pulse of exactly one cycle.
- Latency from a din edge to an idle change:
  - din falling to idle rising: SYNC_STAGES + glitch_ticks + 1 + idle_threshold + 1 edges.
  - din rising to idle falling: SYNC_STAGES + glitch_ticks + 2 edges.
  - f is 0 out of reset, so lines held low report idle idle_threshold+1 edges after reset deasserts.
- Live threshold:
  - Lowering idle_threshold to <= cnt asserts idle on the next edge.
  - Raising it while idle==1 does not deassert idle.
  - idle_threshold=0 asserts idle one edge after f is low.
- Enable gating:
  - Clearing enable_mask[i] drops idle[i] next edge with no frame_start.
  - Setting it restarts counting from cnt=0.
- Aggregates are combinational from the registered idle and the enable_mask input:
  - any_idle = |idle
  - all_idle = (enable_mask!=0) & &(idle | ~enable_mask)
- Channels are fully independent; simultaneous events on multiple channels are all reported in the same cycle.

Test Plan:
- Reset idle: defaults, mask=4'hF, threshold=10, glitch=0, din=0, release reset -> idle=4'hF exactly 11 edges later; single idle_start pulse on all channels; any_idle=all_idle=1.
- Frame latency: threshold=100, glitch=2, ch0 idle, din[0]=1 for 20 cycles -> 6 edges later idle[0] falls with frame_start[0] in the same cycle. Then din[0]=0 -> idle[0] and idle_start[0] rise 2+3+101=106 edges after the din fall.
- Glitch rejection: glitch=2, ch1 idle:
  - din[1] high for 2 cycles -> idle[1] stays 1, no pulses.
  - din[1] high for 3 cycles -> frame_start[1] fires.
  - glitch=0 with a 1-cycle high -> accepted.
- Live threshold: threshold=1000, ch2 low for 200 edges after idle cleared, then threshold=50 -> idle[2] and idle_start[2] assert on the next edge. Raising threshold to 2000 -> idle[2] stays 1.
- Mask: mask=4'b1011 with all lines low and idle -> idle[2]=0, no pulses on ch2, all_idle=1. mask=4'h0 -> all_idle=0. Re-enable ch2 -> idle[2] asserts threshold+1 edges later.
- Reset mid-operation: counters part-way, channel 3 filter mid-deglitch, pulse reset for 1 cycle -> all outputs 0 the next cycle. Counting restarts from 0, and the idle timing matches the first scenario.

Source files
------------

// File: rtl/ws2812b_idle_monitor.sv
// ws2812b_idle_monitor: multi-channel WS2812B line-idle (latch/reset) monitor.
// Each channel synchronises its data line, deglitches it, then times low periods.
//
// Ports:
//   clk             system clock
//   reset           synchronous, active-high reset
//   din             asynchronous WS2812B data lines, one bit per channel
//   enable_mask     per-channel enable for idle counting
//   idle_threshold  low time (clock cycles) needed before a line reads idle
//   glitch_ticks    a level change is accepted after glitch_ticks+1 stable cycles
//   idle            registered idle level per channel
//   idle_start      one-cycle pulse when idle rises
//   frame_start     one-cycle pulse when idle falls (new frame data seen)
//   any_idle        at least one channel idle
//   all_idle        every enabled channel idle; 0 when no channel is enabled

module ws2812b_idle_monitor #(
    parameter int NUM_CH      = 4,
    parameter int CNT_W       = 16,
    parameter int GLITCH_W    = 3,
    parameter int SYNC_STAGES = 2
) (
    input  logic                clk,
    input  logic                reset,
    input  logic [NUM_CH-1:0]   din,
    input  logic [NUM_CH-1:0]   enable_mask,
    input  logic [CNT_W-1:0]    idle_threshold,
    input  logic [GLITCH_W-1:0] glitch_ticks,
    output logic [NUM_CH-1:0]   idle,
    output logic [NUM_CH-1:0]   idle_start,
    output logic [NUM_CH-1:0]   frame_start,
    output logic                any_idle,
    output logic                all_idle
);

    // ------------------------------------------------------------------
    // Synchroniser chain, shared across channels (one vector per stage).
    // It runs regardless of enable_mask so a re-enabled channel sees a
    // settled level immediately.
    // ------------------------------------------------------------------
    logic [NUM_CH-1:0] sync_q [SYNC_STAGES];
    logic [NUM_CH-1:0] s;

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int k = 0; k < SYNC_STAGES; k++) begin
                sync_q[k] <= '0;
            end
        end else begin
            sync_q[0] <= din;
            for (int k = 1; k < SYNC_STAGES; k++) begin
                sync_q[k] <= sync_q[k-1];
            end
        end
    end

    assign s = sync_q[SYNC_STAGES-1];

    // ------------------------------------------------------------------
    // Per-channel deglitch filter and idle timer.
    // ------------------------------------------------------------------
    for (genvar i = 0; i < NUM_CH; i++) begin : g_ch

        logic                f;
        logic [GLITCH_W-1:0] gcnt;
        logic [CNT_W-1:0]    cnt;
        logic                idle_q;
        logic                start_q;
        logic                frame_q;

        // The filtered level only follows s once s has disagreed with it
        // on glitch_ticks+1 consecutive edges; any agreement restarts the
        // run. gcnt never exceeds glitch_ticks, so it cannot wrap.
        always_ff @(posedge clk) begin
            if (reset) begin
                f    <= 1'b0;
                gcnt <= '0;
            end else if (s[i] == f) begin
                gcnt <= '0;
            end else if (gcnt >= glitch_ticks) begin
                f    <= s[i];
                gcnt <= '0;
            end else begin
                gcnt <= gcnt + GLITCH_W'(1);
            end
        end

        // Idle timer. cnt stops at the threshold, so it never overflows.
        // Once idle is set it is held while the line stays low, even if
        // the threshold is raised afterwards; only a high level or a
        // disable clears it. A disable never produces frame_start.
        always_ff @(posedge clk) begin
            if (reset) begin
                cnt     <= '0;
                idle_q  <= 1'b0;
                start_q <= 1'b0;
                frame_q <= 1'b0;
            end else begin
                start_q <= 1'b0;
                frame_q <= 1'b0;
                if (!enable_mask[i]) begin
                    cnt    <= '0;
                    idle_q <= 1'b0;
                end else if (f) begin
                    cnt     <= '0;
                    idle_q  <= 1'b0;
                    frame_q <= idle_q;
                end else if (cnt < idle_threshold) begin
                    cnt <= cnt + CNT_W'(1);
                end else if (!idle_q) begin
                    idle_q  <= 1'b1;
                    start_q <= 1'b1;
                end
            end
        end

        assign idle[i]        = idle_q;
        assign idle_start[i]  = start_q;
        assign frame_start[i] = frame_q;
    end

    // ------------------------------------------------------------------
    // Aggregates: disabled channels count as idle for all_idle, but an
    // all-disabled mask must not report everything idle.
    // ------------------------------------------------------------------
    assign any_idle = |idle;
    assign all_idle = (enable_mask != '0) && (&(idle | ~enable_mask));

endmodule

// File: tb/tb_ws2812b_idle_monitor.sv
// tb_ws2812b_idle_monitor: scoreboard bench for ws2812b_idle_monitor.
// Reference model works on run lengths of the sampled and filtered lines.

module tb_ws2812b_idle_monitor;

    localparam int N  = 4;
    localparam int CW = 16;
    localparam int GW = 3;
    localparam int SS = 2;

    logic          clk = 1'b0;
    logic          reset;
    logic [N-1:0]  din;
    logic [N-1:0]  mask;
    logic [CW-1:0] thr;
    logic [GW-1:0] gt;
    logic [N-1:0]  idle;
    logic [N-1:0]  idle_start;
    logic [N-1:0]  frame_start;
    logic          any_idle;
    logic          all_idle;

    ws2812b_idle_monitor #(
        .NUM_CH(N), .CNT_W(CW), .GLITCH_W(GW), .SYNC_STAGES(SS)
    ) dut (
        .clk(clk),
        .reset(reset),
        .din(din),
        .enable_mask(mask),
        .idle_threshold(thr),
        .glitch_ticks(gt),
        .idle(idle),
        .idle_start(idle_start),
        .frame_start(frame_start),
        .any_idle(any_idle),
        .all_idle(all_idle)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [N-1:0] idle;
        logic [N-1:0] st;
        logic [N-1:0] fr;
    } exp_t;

    exp_t exp_q[$];
    int   tests = 0;
    int   fails = 0;

    task automatic check(string nm, logic [31:0] act, logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    // ---------------- reference model ----------------
    // delay line of SS samples, run length of the sampled level,
    // filtered level, and run length of enabled low time.
    logic [N-1:0] m_sh [SS];
    logic [N-1:0] m_prev_s;
    logic [N-1:0] m_f;
    logic [N-1:0] m_idle;
    int           m_srun [N];
    int           m_low  [N];

    task automatic model_step(output exp_t e);
        logic [N-1:0] sv;
        e.st = '0;
        e.fr = '0;
        if (reset) begin
            for (int k = 0; k < SS; k++) m_sh[k] = '0;
            m_f      = '0;
            m_prev_s = '0;
            m_idle   = '0;
            for (int i = 0; i < N; i++) begin
                m_srun[i] = 0;
                m_low[i]  = 0;
            end
        end else begin
            sv = m_sh[SS-1];
            for (int i = 0; i < N; i++) begin
                if (!mask[i] || m_f[i]) begin
                    e.fr[i]   = mask[i] && m_f[i] && m_idle[i];
                    m_idle[i] = 1'b0;
                    m_low[i]  = 0;
                end else begin
                    if (!m_idle[i] && m_low[i] >= int'(thr)) begin
                        m_idle[i] = 1'b1;
                        e.st[i]   = 1'b1;
                    end
                    if (m_low[i] < (1 << 20)) m_low[i]++;
                end
            end
            for (int i = 0; i < N; i++) begin
                if (sv[i] == m_prev_s[i]) begin
                    if (m_srun[i] < (1 << 20)) m_srun[i]++;
                end else begin
                    m_srun[i] = 1;
                end
                m_prev_s[i] = sv[i];
                if (sv[i] != m_f[i] && m_srun[i] >= int'(gt) + 1)
                    m_f[i] = sv[i];
            end
            for (int k = SS - 1; k > 0; k--) m_sh[k] = m_sh[k-1];
            m_sh[0] = din;
        end
        e.idle = m_idle;
    endtask

    // One clock: model sees the same inputs the DUT samples; inputs
    // may be changed by the caller 2 time units after the edge.
    task automatic tick();
        exp_t e;
        @(posedge clk);
        model_step(e);
        exp_q.push_back(e);
        #2;
    endtask

    // ---------------- monitor ----------------
    logic [N-1:0] ex_all_term;
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                check("idle", 32'(idle), 32'(e.idle));
                check("idle_start", 32'(idle_start), 32'(e.st));
                check("frame_start", 32'(frame_start), 32'(e.fr));
                check("any_idle", 32'(any_idle), 32'(|e.idle));
                ex_all_term = e.idle | ~mask;
                check("all_idle", 32'(all_idle),
                      32'((mask != '0) && (&ex_all_term)));
            end
        end
    end

    // Count edges until (idle & sel) == want, bounded by maxn.
    task automatic measure(string nm, logic [N-1:0] sel, logic [N-1:0] want,
                           int exp_n, int maxn);
        int n = 0;
        while (((idle & sel) !== want) && n < maxn) begin
            tick();
            n++;
        end
        check(nm, 32'(n), 32'(exp_n));
    endtask

    // ---------------- stimulus ----------------
    int hold [N];

    initial begin
        reset = 1'b1;
        din   = '0;
        mask  = 4'hF;
        thr   = 16'd10;
        gt    = 3'd0;
        repeat (3) tick();
        check("reset_idle_low", 32'(idle), 32'h0);
        reset = 1'b0;
        measure("reset_to_idle", 4'hF, 4'hF, 11, 40);
        check("all_idle_after_reset", 32'(all_idle), 32'h1);

        // frame latency
        thr = 16'd100;
        gt  = 3'd2;
        din[0] = 1'b1;
        measure("rise_to_frame", 4'h1, 4'h0, 6, 30);
        repeat (14) tick();
        din[0] = 1'b0;
        measure("fall_to_idle", 4'h1, 4'h1, 106, 300);

        // glitch rejection on ch1
        din[1] = 1'b1;
        repeat (2) tick();
        din[1] = 1'b0;
        repeat (10) tick();
        check("glitch2_rejected", 32'(idle[1]), 32'h1);
        din[1] = 1'b1;
        repeat (3) tick();
        din[1] = 1'b0;
        measure("glitch3_accepted", 4'h2, 4'h0, 3, 20);
        repeat (150) tick();
        check("ch1_reidle", 32'(idle[1]), 32'h1);
        gt = 3'd0;
        din[1] = 1'b1;
        tick();
        din[1] = 1'b0;
        measure("glitch0_accepted", 4'h2, 4'h0, 3, 20);
        repeat (120) tick();

        // live threshold on ch2
        thr = 16'd1000;
        din[2] = 1'b1;
        repeat (5) tick();
        check("ch2_cleared", 32'(idle[2]), 32'h0);
        din[2] = 1'b0;
        repeat (200) tick();
        thr = 16'd50;
        measure("thr_lowered", 4'h4, 4'h4, 1, 5);
        thr = 16'd2000;
        repeat (20) tick();
        check("thr_raised_hold", 32'(idle[2]), 32'h1);

        // enable mask
        thr = 16'd10;
        repeat (20) tick();
        mask = 4'b1011;
        tick();
        check("mask_ch2_off", 32'(idle[2]), 32'h0);
        check("mask_all_idle", 32'(all_idle), 32'h1);
        mask = 4'h0;
        tick();
        check("mask0_all_idle", 32'(all_idle), 32'h0);
        mask = 4'hF;
        measure("reenable_ch2", 4'h4, 4'h4, 11, 40);
        repeat (5) tick();

        // reset mid-operation
        din = 4'hF;
        repeat (6) tick();
        din = 4'h0;
        repeat (8) tick();
        gt = 3'd2;
        din[3] = 1'b1;
        tick();
        reset = 1'b1;
        tick();
        check("midreset_idle", 32'(idle), 32'h0);
        check("midreset_any", 32'(any_idle), 32'h0);
        reset = 1'b0;
        din = 4'h0;
        gt  = 3'd0;
        measure("midreset_reidle", 4'hF, 4'hF, 11, 40);

        // randomized phase
        for (int i = 0; i < N; i++) hold[i] = 0;
        for (int c = 0; c < 4000; c++) begin
            for (int i = 0; i < N; i++) begin
                if (hold[i] == 0) begin
                    din[i]  = ~din[i];
                    hold[i] = int'($urandom_range(1, 25));
                end else begin
                    hold[i]--;
                end
            end
            if ($urandom_range(0, 99) == 0) gt = GW'($urandom_range(0, 3));
            if ($urandom_range(0, 99) == 0) thr = CW'($urandom_range(0, 20));
            if ($urandom_range(0, 149) == 0) mask = N'($urandom);
            reset = ($urandom_range(0, 499) == 0);
            tick();
        end
        reset = 1'b0;
        repeat (3) tick();
        @(negedge clk);
        #1;
        check("queue_drained", 32'(exp_q.size()), 32'h0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
